// File: rtl/param_reg_stack_if.sv
// Bundles the stack opcode inputs and the stack/status outputs into one bus.
// Latency: none; plain wires between the issuing datapath and the stack.
// Backpressure: none; the stack accepts one op per clock unconditionally.
//
// Ports (as seen from the stack, slave modport):
//   op_valid/op/in_val  in   opcode strobe, 4-bit opcode, push operand
//   top/next            out  s[0] and s[1]
//   pop_data/pop_valid  out  last popped value and its one-cycle update pulse
//   depth/empty/full    out  valid entry count and its derived status
//   carry/err/err_sticky out add carry or sub borrow, reject pulse, latched reject
interface param_reg_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             op_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             carry;
    logic             err;
    logic             err_sticky;

    modport master (
        output op_valid, op, in_val,
        input  top, next, pop_data, pop_valid, depth, empty, full, carry, err, err_sticky
    );

    modport slave (
        input  op_valid, op, in_val,
        output top, next, pop_data, pop_valid, depth, empty, full, carry, err, err_sticky
    );
endinterface

// File: rtl/param_reg_stack.sv
// Register stack for the stack CPU datapath: push/pop/drop/add/sub/dup/swap/over.
// Latency: every op completes in one cycle; outputs reflect it after the next clk edge.
// Backpressure: none; illegal ops (over/underflow, undefined opcode) are rejected with err.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset; clears all state
//   bus   slave modport of param_reg_stack_if (op inputs, stack and status outputs)
module param_reg_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    param_reg_stack_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [DW-1:0] TWO  = DW'(2);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_PUSH = 4'b1000;
    localparam logic [3:0] OP_POP  = 4'b0001;
    localparam logic [3:0] OP_DROP = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_DUP  = 4'b0101;
    localparam logic [3:0] OP_OVER = 4'b0110;
    localparam logic [3:0] OP_SWAP = 4'b0111;

    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [WIDTH-1:0] up    [DEPTH];
    logic [WIDTH-1:0] down  [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             has1, has2, room, ok;

    // Shifted views of the stack. s[0] of 'up' is replaced by the op's new top;
    // 'down' zero-fills the bottom so entries beyond depth stay 0.
    always_comb begin
        up[0] = '0;
        for (int k = 1; k < DEPTH; k++) up[k] = stk_q[k-1];
    end

    always_comb begin
        down[DEPTH-1] = '0;
        for (int k = 0; k < DEPTH - 1; k++) down[k] = stk_q[k+1];
    end

    assign sum    = {1'b0, stk_q[1]} + {1'b0, stk_q[0]};
    assign diff   = stk_q[1] - stk_q[0];
    assign borrow = stk_q[1] < stk_q[0];

    assign has1 = depth_q != '0;
    assign has2 = depth_q >= TWO;
    assign room = depth_q != DMAX;

    // All state changes sit behind 'ok', so a rejected op leaves everything but
    // err/err_sticky untouched.
    always_comb begin
        stk_d        = stk_q;
        depth_d      = depth_q;
        pop_data_d   = pop_data_q;
        pop_valid_d  = 1'b0;
        carry_d      = carry_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        ok           = 1'b1;
        if (bus.op_valid) begin
            case (bus.op)
                OP_NOP: ok = 1'b1;
                OP_PUSH: begin
                    ok = room;
                    if (ok) begin
                        stk_d    = up;
                        stk_d[0] = bus.in_val;
                        depth_d  = depth_q + ONE;
                    end
                end
                OP_POP, OP_DROP: begin
                    ok = has1;
                    if (ok) begin
                        stk_d   = down;
                        depth_d = depth_q - ONE;
                        if (bus.op == OP_POP) begin
                            pop_data_d  = stk_q[0];
                            pop_valid_d = 1'b1;
                        end
                    end
                end
                OP_ADD, OP_SUB: begin
                    ok = has2;
                    if (ok) begin
                        stk_d   = down;
                        depth_d = depth_q - ONE;
                        if (bus.op == OP_ADD) begin
                            stk_d[0] = sum[WIDTH-1:0];
                            carry_d  = sum[WIDTH];
                        end else begin
                            stk_d[0] = diff;
                            carry_d  = borrow;
                        end
                    end
                end
                OP_DUP: begin
                    ok = has1 && room;
                    if (ok) begin
                        stk_d    = up;
                        stk_d[0] = stk_q[0];
                        depth_d  = depth_q + ONE;
                    end
                end
                OP_OVER: begin
                    ok = has2 && room;
                    if (ok) begin
                        stk_d    = up;
                        stk_d[0] = stk_q[1];
                        depth_d  = depth_q + ONE;
                    end
                end
                OP_SWAP: begin
                    ok = has2;
                    if (ok) begin
                        stk_d[0] = stk_q[1];
                        stk_d[1] = stk_q[0];
                    end
                end
                default: ok = 1'b0;
            endcase
            if (!ok) begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stk_q[k] <= '0;
            depth_q      <= '0;
            pop_data_q   <= '0;
            pop_valid_q  <= 1'b0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            stk_q        <= stk_d;
            depth_q      <= depth_d;
            pop_data_q   <= pop_data_d;
            pop_valid_q  <= pop_valid_d;
            carry_q      <= carry_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.top        = stk_q[0];
    assign bus.next       = stk_q[1];
    assign bus.pop_data   = pop_data_q;
    assign bus.pop_valid  = pop_valid_q;
    assign bus.depth      = depth_q;
    assign bus.empty      = depth_q == '0;
    assign bus.full       = depth_q == DMAX;
    assign bus.carry      = carry_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_param_reg_stack.sv
// Directed-vector bench for param_reg_stack with a queue-based scoreboard.
// Latency: expected values are queued at the op's clock edge and checked on the next falling edge.
// Backpressure: none; one op is issued per cycle.
module tb_param_reg_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 10;

    localparam logic [3:0] NOP  = 4'b0000;
    localparam logic [3:0] PUSH = 4'b1000;
    localparam logic [3:0] POP  = 4'b0001;
    localparam logic [3:0] DROP = 4'b0010;
    localparam logic [3:0] ADD  = 4'b0011;
    localparam logic [3:0] SUB  = 4'b0100;
    localparam logic [3:0] DUP  = 4'b0101;
    localparam logic [3:0] OVER = 4'b0110;
    localparam logic [3:0] SWAP = 4'b0111;
    localparam logic [3:0] UNDEF = 4'b1111;

    typedef struct {
        int          id;
        logic [15:0] top;
        logic [15:0] nxt;
        logic [3:0]  depth;
        logic        carry;
        logic        err;
        logic        sticky;
        logic        pv;
        logic [15:0] pd;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   vid;
    exp_t sb[$];

    param_reg_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL v%0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    task automatic check(input exp_t e);
        vectors++;
        chk(e.id, "top",        bus.top,                e.top);
        chk(e.id, "next",       bus.next,               e.nxt);
        chk(e.id, "depth",      16'(bus.depth),         16'(e.depth));
        chk(e.id, "empty",      16'(bus.empty),         16'(e.depth == 4'd0));
        chk(e.id, "full",       16'(bus.full),          16'(e.depth == 4'd10));
        chk(e.id, "carry",      16'(bus.carry),         16'(e.carry));
        chk(e.id, "err",        16'(bus.err),           16'(e.err));
        chk(e.id, "err_sticky", 16'(bus.err_sticky),    16'(e.sticky));
        chk(e.id, "pop_valid",  16'(bus.pop_valid),     16'(e.pv));
        chk(e.id, "pop_data",   bus.pop_data,           e.pd);
    endtask

    function automatic exp_t zero_exp(input int id);
        exp_t e;
        e.id = id; e.top = '0; e.nxt = '0; e.depth = '0; e.carry = 1'b0;
        e.err = 1'b0; e.sticky = 1'b0; e.pv = 1'b0; e.pd = '0;
        return e;
    endfunction

    // Drive one op, queue its hand-computed result at the clock edge that executes it.
    task automatic apply(input logic v, input logic [3:0] o, input logic [15:0] val,
                         input logic [15:0] et, input logic [15:0] en, input int ed,
                         input logic ec, input logic ee, input logic es,
                         input logic ep, input logic [15:0] epd);
        exp_t e;
        bus.op_valid = v;
        bus.op       = o;
        bus.in_val   = val;
        vid++;
        e.id = vid; e.top = et; e.nxt = en; e.depth = 4'(ed); e.carry = ec;
        e.err = ee; e.sticky = es; e.pv = ep; e.pd = epd;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are valid every cycle following an op.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vectors = 0; miscompares = 0; vid = 0;
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op = NOP; bus.in_val = '0;
        repeat (2) @(negedge clk);
        check(zero_exp(0));
        rst = 1'b0;

        //     v  op    val       top      next     d  c  e  s  pv pd
        apply(1, PUSH, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'h0003, 16'h0003, 16'h0005, 2, 0, 0, 0, 0, 16'h0000);
        apply(1, SUB,  16'h0000, 16'h0002, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'h0007, 16'h0007, 16'h0002, 2, 0, 0, 0, 0, 16'h0000);
        apply(1, SUB,  16'h0000, 16'hFFFB, 16'h0000, 1, 1, 0, 0, 0, 16'h0000);
        apply(1, DROP, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'h0002, 16'h0002, 16'h0000, 1, 1, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'h0003, 16'h0003, 16'h0002, 2, 1, 0, 0, 0, 16'h0000);
        apply(1, ADD,  16'h0000, 16'h0005, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'hFFFF, 16'hFFFF, 16'h0005, 2, 0, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'h0001, 16'h0001, 16'hFFFF, 3, 0, 0, 0, 0, 16'h0000);
        apply(1, ADD,  16'h0000, 16'h0000, 16'h0005, 2, 1, 0, 0, 0, 16'h0000);
        apply(0, PUSH, 16'h1234, 16'h0000, 16'h0005, 2, 1, 0, 0, 0, 16'h0000);
        apply(1, NOP,  16'h1234, 16'h0000, 16'h0005, 2, 1, 0, 0, 0, 16'h0000);
        apply(1, DROP, 16'h0000, 16'h0005, 16'h0000, 1, 1, 0, 0, 0, 16'h0000);
        apply(1, DROP, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 1, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'h5555, 16'h5555, 16'hAAAA, 2, 1, 0, 0, 0, 16'h0000);
        apply(1, SWAP, 16'h0000, 16'hAAAA, 16'h5555, 2, 1, 0, 0, 0, 16'h0000);
        apply(1, OVER, 16'h0000, 16'h5555, 16'hAAAA, 3, 1, 0, 0, 0, 16'h0000);
        apply(1, DUP,  16'h0000, 16'h5555, 16'h5555, 4, 1, 0, 0, 0, 16'h0000);
        apply(1, DROP, 16'h0000, 16'h5555, 16'hAAAA, 3, 1, 0, 0, 0, 16'h0000);
        apply(1, DROP, 16'h0000, 16'hAAAA, 16'h5555, 2, 1, 0, 0, 0, 16'h0000);
        apply(1, DROP, 16'h0000, 16'h5555, 16'h0000, 1, 1, 0, 0, 0, 16'h0000);
        apply(1, DROP, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
        apply(1, POP,  16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 1, 0, 16'h0000);
        apply(1, PUSH, 16'h0009, 16'h0009, 16'h0000, 1, 1, 0, 1, 0, 16'h0000);
        apply(1, POP,  16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 16'h0009);
        apply(1, NOP,  16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 16'h0009);
        apply(1, PUSH, 16'h0004, 16'h0004, 16'h0000, 1, 1, 0, 1, 0, 16'h0009);
        apply(1, ADD,  16'h0000, 16'h0004, 16'h0000, 1, 1, 1, 1, 0, 16'h0009);
        apply(1, DUP,  16'h0000, 16'h0004, 16'h0004, 2, 1, 0, 1, 0, 16'h0009);
        apply(1, SUB,  16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 16'h0009);
        apply(1, OVER, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 1, 0, 16'h0009);
        apply(1, DROP, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0009);
        apply(1, UNDEF,16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'h0009);
        apply(1, DUP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'h0009);
        apply(1, SWAP, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'h0009);
        apply(1, PUSH, 16'h00EE, 16'h00EE, 16'h0000, 1, 0, 0, 1, 0, 16'h0009);

        // Asynchronous reset between clock edges, with a push presented that must be aborted.
        bus.op_valid = 1'b1; bus.op = PUSH; bus.in_val = 16'h0077;
        #2 rst = 1'b1;
        #1 check(zero_exp(100));
        @(negedge clk);
        check(zero_exp(101));
        bus.op_valid = 1'b0; bus.op = NOP;
        rst = 1'b0;

        for (int k = 1; k <= 10; k++)
            apply(1, PUSH, 16'(k), 16'(k), 16'(k - 1), k, 0, 0, 0, 0, 16'h0000);
        apply(1, PUSH, 16'h000B, 16'h000A, 16'h0009, 10, 0, 1, 1, 0, 16'h0000);
        apply(1, OVER, 16'h0000, 16'h000A, 16'h0009, 10, 0, 1, 1, 0, 16'h0000);
        apply(1, DUP,  16'h0000, 16'h000A, 16'h0009, 10, 0, 1, 1, 0, 16'h0000);
        apply(1, POP,  16'h0000, 16'h0009, 16'h0008,  9, 0, 0, 1, 1, 16'h000A);
        apply(1, PUSH, 16'h000A, 16'h000A, 16'h0009, 10, 0, 0, 1, 0, 16'h000A);
        apply(1, ADD,  16'h0000, 16'h0013, 16'h0008,  9, 0, 0, 1, 0, 16'h000A);
        apply(0, NOP,  16'h0000, 16'h0013, 16'h0008,  9, 0, 0, 1, 0, 16'h000A);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected results never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
